// File: rtl/pwm_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_pkg : shared width default and saturating duty step helper        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package pwm_pkg;

  localparam int PWM_WIDTH_DEF = 3;

  // Saturating +/-1 within [0, 2^width-1]; simultaneous inc and dec cancel.
  function automatic logic [31:0] sat_step(
    input logic [31:0] val,
    input logic        inc,
    input logic        dec,
    input int          width
  );
    logic [31:0] max_val;
    max_val  = (32'd1 << width) - 32'd1;
    sat_step = val;
    if (inc && !dec && (val < max_val)) begin
      sat_step = val + 32'd1;
    end else if (dec && !inc && (val != 32'd0)) begin
      sat_step = val - 32'd1;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_if : control and output signals of the PWM generator              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEF
) ();

  logic             en;
  logic             duty_inc;
  logic             duty_dec;
  logic [WIDTH-1:0] duty;
  logic             PWM_out;

  modport master (
    output en,
    output duty_inc,
    output duty_dec,
    output duty,
    input  PWM_out
  );

  modport slave (
    input  en,
    input  duty_inc,
    input  duty_dec,
    input  duty,
    output PWM_out
  );

endinterface
`default_nettype wire

// File: rtl/pwm_step_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_step_ctrl : duty register with initial load and saturating step.  |
// | PWM_EDGE_DETECT_EN selects rising-edge inc/dec instead of level.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pwm_step_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loaded,
  input  logic [WIDTH-1:0] duty_init,
  input  logic             inc_req,
  input  logic             dec_req,
  output logic [WIDTH-1:0] duty_cycle
);

  logic             inc_act;
  logic             dec_act;
  logic [WIDTH-1:0] duty_cycle_d;
  logic [WIDTH-1:0] duty_cycle_q;

`ifdef PWM_EDGE_DETECT_EN
  logic inc_d;
  logic dec_d;
  logic inc_q;
  logic dec_q;

  always_comb begin
    inc_d   = inc_req;
    dec_d   = dec_req;
    inc_act = inc_req & ~inc_q;
    dec_act = dec_req & ~dec_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      inc_q <= inc_d;
      dec_q <= dec_d;
    end
  end
`else
  always_comb begin
    inc_act = inc_req;
    dec_act = dec_req;
  end
`endif

  // Until the first post-reset edge the register takes the external value.
  always_comb begin
    duty_cycle_d = duty_cycle_q;
    if (!loaded) begin
      duty_cycle_d = duty_init;
    end else begin
      duty_cycle_d = WIDTH'(sat_step(32'(duty_cycle_q), inc_act, dec_act, WIDTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_cycle_q <= '0;
    end else begin
      duty_cycle_q <= duty_cycle_d;
    end
  end

  assign duty_cycle = duty_cycle_q;

endmodule
`default_nettype wire

// File: rtl/pwm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm : fixed 2^WIDTH-clock frame PWM with adjustable duty register.    |
// | Build option PWM_EDGE_DETECT_EN: edge-triggered duty inc/dec.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pwm
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  pwm_if.slave bus
);

  logic [WIDTH-1:0] counter_d;
  logic [WIDTH-1:0] counter_q;
  logic             loaded_d;
  logic             loaded_q;
  logic             pwm_out_d;
  logic             pwm_out_q;
  logic [WIDTH-1:0] duty_cycle;

  pwm_step_ctrl #(
    .WIDTH (WIDTH)
  ) u_step_ctrl (
    .clk        (clk),
    .rst        (rst),
    .loaded     (loaded_q),
    .duty_init  (bus.duty),
    .inc_req    (bus.duty_inc),
    .dec_req    (bus.duty_dec),
    .duty_cycle (duty_cycle)
  );

  // Counter wraps naturally at 2^WIDTH; the frame is never restarted on duty change.
  always_comb begin
    counter_d = counter_q;
    if (bus.en) begin
      counter_d = counter_q + WIDTH'(1);
    end
    loaded_d  = 1'b1;
    pwm_out_d = bus.en & loaded_q & (counter_q < duty_cycle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
      loaded_q  <= 1'b0;
      pwm_out_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      loaded_q  <= loaded_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign bus.PWM_out = pwm_out_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pwm : directed self-checking bench for pwm (WIDTH=3)               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_pwm;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   hi;
  bit   found;

  pwm_if #(.WIDTH(3)) bus ();

  pwm #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step();
      if (bus.PWM_out === 1'b1) cnt++;
    end
  endtask

  task automatic pulse_inc();
    @(negedge clk);
    bus.duty_inc = 1'b1;
    @(negedge clk);
    bus.duty_inc = 1'b0;
  endtask

  task automatic pulse_dec();
    @(negedge clk);
    bus.duty_dec = 1'b1;
    @(negedge clk);
    bus.duty_dec = 1'b0;
  endtask

  bit exp_start[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b1, 1'b1, 1'b1, 1'b1};
  bit exp_resume[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                         1'b1, 1'b0};

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b0;
    bus.en       = 1'b1;
    bus.duty_inc = 1'b0;
    bus.duty_dec = 1'b0;
    bus.duty     = 3'd4;

    // Held in reset: output stays low across clock edges.
    step();
    check("reset_out_a", {7'd0, bus.PWM_out}, 8'd0);
    step();
    check("reset_out_b", {7'd0, bus.PWM_out}, 8'd0);

    // Release with duty=4: load cycle low, then counter-1 < 4 pattern.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("start_wave_%0d", i), {7'd0, bus.PWM_out}, {7'd0, exp_start[i]});
    end

    // Duty input is only sampled once after reset.
    @(negedge clk);
    bus.duty = 3'd7;
    count_high(8, hi);
    check("duty_captured_once", 8'(hi), 8'd4);

    pulse_inc();
    count_high(8, hi);
    check("inc_to_5", 8'(hi), 8'd5);
    pulse_inc();
    count_high(8, hi);
    check("inc_to_6", 8'(hi), 8'd6);
    pulse_inc();
    count_high(8, hi);
    check("inc_to_7", 8'(hi), 8'd7);
    pulse_inc();
    count_high(8, hi);
    check("inc_sat_7", 8'(hi), 8'd7);

    repeat (8) pulse_dec();
    count_high(16, hi);
    check("dec_sat_0", 8'(hi), 8'd0);

    repeat (4) pulse_inc();
    count_high(8, hi);
    check("inc_from_0_to_4", 8'(hi), 8'd4);

    @(negedge clk);
    bus.duty_inc = 1'b1;
    bus.duty_dec = 1'b1;
    @(negedge clk);
    bus.duty_inc = 1'b0;
    bus.duty_dec = 1'b0;
    count_high(8, hi);
    check("inc_dec_cancel", 8'(hi), 8'd4);

    // inc held for three rising edges.
    @(negedge clk);
    bus.duty_inc = 1'b1;
    repeat (3) @(negedge clk);
    bus.duty_inc = 1'b0;
    count_high(8, hi);
`ifdef PWM_EDGE_DETECT_EN
    check("inc_held_3clk", 8'(hi), 8'd5);
`else
    check("inc_held_3clk", 8'(hi), 8'd7);
`endif

    // Async reset while output is high.
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      if (bus.PWM_out === 1'b1) found = 1'b1;
    end
    check("find_high_before_rst", {7'd0, found}, 8'd1);
    #2;
    rst      = 1'b0;
    bus.duty = 3'd3;
    #1;
    check("async_rst_out", {7'd0, bus.PWM_out}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reload with duty=3, then freeze after counter reaches 2.
    step();
    check("reload_wave_0", {7'd0, bus.PWM_out}, 8'd0);
    step();
    check("reload_wave_1", {7'd0, bus.PWM_out}, 8'd1);
    @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("en_off_%0d", i), {7'd0, bus.PWM_out}, 8'd0);
    end
    @(negedge clk);
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("resume_wave_%0d", i), {7'd0, bus.PWM_out}, {7'd0, exp_resume[i]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
